ysyx_040066_dmem_resp: RTL

Data-memory responder for the CPU data port: the slave end of the core's `MemRd`/`MemWr` → `data_valid`/`data_error`/`data_Rd` handshake. It serves one request at a time from an internal byte-masked 64-bit RAM and inserts a programmable wait latency. It range-checks and alignment-checks every access, then returns a single-cycle `data_valid` pulse that releases the core's memory stall. It sits beside the CPU in simulation and FPGA tops, in place of an external memory model.

---
 rtl/ysyx_040066_mem_pkg.sv | 18 +
 rtl/ysyx_040066_dmem_array.sv | 39 +++
 rtl/ysyx_040066_dmem_resp.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ysyx_040066_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, access-size codes and the default RAM base address.
package ysyx_040066_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] LEN_B = 3'd0;
    localparam logic [2:0] LEN_H = 3'd1;
    localparam logic [2:0] LEN_W = 3'd2;
    localparam logic [2:0] LEN_D = 3'd3;

    localparam logic [63:0] DEFAULT_BASE = 64'h8000_0000;

endpackage

// File: rtl/ysyx_040066_dmem_array.sv
// Doubleword RAM with per-byte write enables and a registered read port.
// The read register can be loaded with zero so faulted and write responses return 0.
module ysyx_040066_dmem_array #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [7:0]            be_i,
   input  logic [DEPTH_LOG2-1:0] idx_i,
   input  logic [63:0]           wdata_i,
   input  logic                  rd_en_i,
   input  logic                  rd_clr_i,
   output logic [63:0]           rdata_o
);

   logic [63:0] mem_q [2**DEPTH_LOG2];
   logic [63:0] rdata_q;

   // RAM contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < 8; b++) begin
            if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (rd_en_i) begin
         rdata_q <= rd_clr_i ? '0 : mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_040066_dmem_resp.sv
// Slave end of the core's MemRd/MemWr data handshake: FSM, wait counter,
// request latch and access-fault checks around the doubleword RAM.
module ysyx_040066_dmem_resp
    import ysyx_040066_mem_pkg::*;
#(
    parameter logic [63:0] BASE       = DEFAULT_BASE,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [63:0] addr,
    input  logic [2:0]  wr_len,
    input  logic [7:0]  wr_mask,
    input  logic [63:0] data_Wr,
    output logic        data_valid,
    output logic        data_error,
    output logic [63:0] data_Rd
);

    localparam logic [64:0] END_ADDR = {1'b0, BASE} + (65'd8 << DEPTH_LOG2);
    localparam logic [3:0]  LAT_CNT  = 4'(LATENCY);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [7:0]            mask_q;
    logic [63:0]           wdata_q;
    logic                  wr_q, fault_q, data_error_q;
    logic                  latch_en, enter_resp, misalign, cur_fault;
    logic [63:0]           offset;
    logic [DEPTH_LOG2-1:0] cur_idx, sel_idx;
    logic                  in_idle, sel_wr, sel_fault;
    logic [7:0]            sel_mask;
    logic [63:0]           sel_data;
    logic                  unused_offset_bits;

    always_comb begin
        case (wr_len)
            LEN_B:   misalign = 1'b0;
            LEN_H:   misalign = addr[0];
            LEN_W:   misalign = |addr[1:0];
            LEN_D:   misalign = |addr[2:0];
            default: misalign = 1'b1;
        endcase
    end

    // 65-bit compares keep addresses near the top of the space from wrapping into range.
    assign cur_fault = ({1'b0, addr} < {1'b0, BASE}) || ({1'b0, addr} >= END_ADDR)
                       || misalign || (MemRd && MemWr);
    assign offset    = addr - BASE;
    assign cur_idx   = offset[DEPTH_LOG2+2:3];
    assign unused_offset_bits = ^{offset[63:DEPTH_LOG2+3], offset[2:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_en   = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemRd || MemWr) begin
                    latch_en = 1'b1;
                    cnt_d    = LAT_CNT;
                    if (LATENCY == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!(MemRd || MemWr)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero latency the access commits straight from the live request.
    assign in_idle   = (state_q == ST_IDLE);
    assign sel_wr    = in_idle ? MemWr     : wr_q;
    assign sel_fault = in_idle ? cur_fault : fault_q;
    assign sel_idx   = in_idle ? cur_idx   : idx_q;
    assign sel_mask  = in_idle ? wr_mask   : mask_q;
    assign sel_data  = in_idle ? data_Wr   : wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            fault_q      <= 1'b0;
            data_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                idx_q   <= cur_idx;
                mask_q  <= wr_mask;
                wdata_q <= data_Wr;
                wr_q    <= MemWr;
                fault_q <= cur_fault;
            end
            if (enter_resp) data_error_q <= sel_fault;
        end
    end

    ysyx_040066_dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .we_i     (enter_resp && sel_wr && !sel_fault),
        .be_i     (sel_mask),
        .idx_i    (sel_idx),
        .wdata_i  (sel_data),
        .rd_en_i  (enter_resp),
        .rd_clr_i (sel_wr || sel_fault),
        .rdata_o  (data_Rd)
    );

    assign data_valid = (state_q == ST_RESP);
    assign data_error = data_error_q;

endmodule
